// File: rtl/ifmap_row_feeder.sv
// ifmap_row_feeder: reads ifmap words linearly from a synchronous-read
// scratch memory. It tags each word with start-of-row and end-of-row flags.
// It then pushes the tagged words into the PE IFMap FIFO through a 2-entry
// skid buffer that is protected by a read-credit limit.
// Optional build macro: IFMAP_PAD_EN. When it is defined, PAD zero words
// surround every row.
//
// FIFO handshake: a word moves into the FIFO in every cycle where
// wen_buf_IFMap is 1. wen_buf_IFMap is raised only while ready_IFMap is 1
// and the skid buffer holds a word. IFMap then carries that word (the skid
// head). Memory side: mem_dout is the read data for the mem_ren/mem_addr
// issued in the previous cycle.
module ifmap_row_feeder #(
  parameter int DATA_WIDTH     = 20,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int ROW_LEN_WIDTH  = 5,
  parameter int ROWS_WIDTH     = 4,
  parameter int PAD            = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr_in,
  input  logic [ROW_LEN_WIDTH-1:0]  row_len_in,
  input  logic [ROWS_WIDTH-1:0]     num_rows_in,
  output logic                      mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_dout,
  input  logic                      ready_IFMap,
  output logic                      wen_buf_IFMap,
  output logic [DATA_WIDTH+1:0]     IFMap,
  output logic                      busy,
  output logic                      done
);

`ifdef IFMAP_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif
  // Pad words per row side actually emitted. This is zero when padding is
  // compiled out, so the slot logic below then degenerates to plain reads.
  localparam int PADS  = PAD_ON ? PAD : 0;
  localparam int W     = DATA_WIDTH + 2;
  // The effective row length (row_len + 2*PADS) needs two extra bits.
  // This holds for PAD up to 2^ROW_LEN_WIDTH.
  localparam int EL_W  = ROW_LEN_WIDTH + 2;
  localparam int TOT_W = EL_W + ROWS_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                    state, state_nxt;
  logic [ROW_LEN_WIDTH-1:0]  row_len_q;
  logic [EL_W-1:0]           eff_len_q, eff_len_in;
  logic [EL_W-1:0]           iss_col, cap_col;
  logic [TOT_W-1:0]          req_left;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr;
  logic                      in_flight, in_flight_pad;
  logic [1:0]                occ;
  logic [W-1:0]              skid0, skid1, cap_word;
  logic                      start_ok, job_empty, issue, is_pad;
  logic                      pop, push, credit_ok, drained;

  assign eff_len_in = EL_W'(row_len_in) + EL_W'(2 * PADS);
  assign start_ok   = (state == S_IDLE) && Start;
  assign job_empty  = (row_len_in == '0) || (num_rows_in == '0);

  // The head pops whenever the FIFO can take it. A returning read always
  // lands in the skid buffer.
  assign pop  = (occ != 2'd0) && ready_IFMap;
  assign push = in_flight;

  // Issue slots outside the memory part of a row are pad slots.
  assign is_pad = (iss_col < EL_W'(PADS)) ||
                  (iss_col >= EL_W'(PADS) + EL_W'(row_len_q));

  // Credit check: the words held plus the words in flight, less the word
  // leaving this cycle, must leave room for one more word.
  always_comb begin
    credit_ok = ({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop});
    issue     = (state == S_RUN) && (req_left != '0) && credit_ok;
    mem_ren   = issue && !is_pad;
    drained   = !in_flight && ((occ == 2'd0) || ((occ == 2'd1) && pop));
    cap_word  = {(cap_col == '0),
                 (cap_col == eff_len_q - EL_W'(1)),
                 (in_flight_pad ? {DATA_WIDTH{1'b0}} : mem_dout)};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. A job is complete once every slot has been issued
  // and the last word leaves the skid buffer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (Start) state_nxt = job_empty ? S_FIN : S_RUN;
      S_RUN:   if (issue && (req_left == TOT_W'(1))) state_nxt = S_DRAIN;
      S_DRAIN: if (drained) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job configuration, the remaining-slot count, the read address and the
  // position of the issue slot within its row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_len_q <= '0;
      eff_len_q <= '0;
      req_left  <= '0;
      rd_addr   <= '0;
      iss_col   <= '0;
    end else if (start_ok) begin
      row_len_q <= row_len_in;
      eff_len_q <= eff_len_in;
      req_left  <= TOT_W'(eff_len_in) * TOT_W'(num_rows_in);
      rd_addr   <= base_addr_in;
      iss_col   <= '0;
    end else if (issue) begin
      req_left <= req_left - TOT_W'(1);
      if (mem_ren) rd_addr <= rd_addr + MEM_ADDR_WIDTH'(1);
      iss_col  <= (iss_col == eff_len_q - EL_W'(1)) ? '0 : iss_col + EL_W'(1);
    end
  end

  // In-flight tracking, plus the column counter used to tag captured words.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_flight     <= 1'b0;
      in_flight_pad <= 1'b0;
      cap_col       <= '0;
    end else begin
      in_flight     <= issue;
      in_flight_pad <= issue && is_pad;
      if (start_ok)  cap_col <= '0;
      else if (push) cap_col <= (cap_col == eff_len_q - EL_W'(1)) ? '0
                                                                  : cap_col + EL_W'(1);
    end
  end

  // 2-entry skid buffer. skid0 is always the head, so IFMap comes straight
  // from a register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ   <= 2'd0;
      skid0 <= '0;
      skid1 <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) skid0 <= cap_word;
          else             skid1 <= cap_word;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= cap_word;
          end else begin
            skid0 <= skid1;
            skid1 <= cap_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr      = rd_addr;
  assign wen_buf_IFMap = pop;
  assign IFMap         = skid0;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_FIN);

endmodule

// File: tb/tb_ifmap_row_feeder.sv
// Testbench for ifmap_row_feeder. It runs directed job vectors from a
// table, then a mid-job reset sequence, then random jobs under random
// backpressure. Every job is checked against a reference stream that is
// built from the memory contents and the row rules.
module tb_ifmap_row_feeder;
  localparam int DW   = 20;
  localparam int AW   = 8;
  localparam int RLW  = 5;
  localparam int RW   = 4;
  localparam int PADP = 1;
`ifdef IFMAP_PAD_EN
  localparam int PADV = PADP;
`else
  localparam int PADV = 0;
`endif
  localparam int W = DW + 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Start = 1'b0;
  logic [AW-1:0] base_addr_in = '0;
  logic [RLW-1:0] row_len_in = '0;
  logic [RW-1:0] num_rows_in = '0;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;
  logic          ready_IFMap = 1'b1;
  logic          wen_buf_IFMap;
  logic [W-1:0]  IFMap;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ifmap_row_feeder #(
    .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .ROW_LEN_WIDTH(RLW),
    .ROWS_WIDTH(RW), .PAD(PADP)
  ) dut (
    .clk(clk), .rst(rst), .Start(Start),
    .base_addr_in(base_addr_in), .row_len_in(row_len_in), .num_rows_in(num_rows_in),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .ready_IFMap(ready_IFMap), .wen_buf_IFMap(wen_buf_IFMap), .IFMap(IFMap),
    .busy(busy), .done(done)
  );

  // Synchronous-read scratch memory. It returns junk when no read is issued.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_ren) mem_dout <= mem[mem_addr];
    else         mem_dout <= DW'($urandom);
  end

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] addr_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference stream: rows of (pad, memory words, pad), read contiguously
  // from base with wrap. sor is on slot 0 and eor on the last slot.
  task automatic build_model(input logic [AW-1:0] base, input int len, input int rows);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            slots;
    exp_q.delete();
    addr_q.delete();
    a     = base;
    slots = len + 2 * PADV;
    if (len != 0) begin
      for (int r = 0; r < rows; r++) begin
        for (int c = 0; c < slots; c++) begin
          if (c < PADV || c >= PADV + len) begin
            d = '0;
          end else begin
            d = mem[a];
            addr_q.push_back(a);
            a = a + AW'(1);
          end
          exp_q.push_back({(c == 0), (c == slots - 1), d});
        end
      end
    end
  endtask

  // ---------------- job vectors ----------------
  // A value of -2 skips that timing check. A value of -1 means the event
  // must never happen.
  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            rows;
    int            st_lo;
    int            st_hi;
    int            ign_rel;
    bit            rnd;
    int            exp_ren;
    int            exp_wen;
    int            exp_done;
  } vec_t;

  // Expected timing with an always-ready FIFO: Start in cycle 0, the first
  // slot issued in cycle 1, the first write in cycle 3, then one word per
  // cycle. done comes the cycle after the last write.
  function automatic vec_t mk(input logic [AW-1:0] base, input int len, input int rows,
                              input int lo, input int hi, input int ign, input bit timed);
    vec_t v;
    bit   empty;
    empty      = (len == 0) || (rows == 0);
    v.base     = base;
    v.len      = len;
    v.rows     = rows;
    v.st_lo    = lo;
    v.st_hi    = hi;
    v.ign_rel  = ign;
    v.rnd      = 1'b0;
    v.exp_ren  = empty ? -1 : 1 + PADV;
    v.exp_wen  = empty ? -1 : 3;
    v.exp_done = !timed ? -2 : (empty ? 1 : 3 + rows * (len + 2 * PADV));
    return v;
  endfunction

  // ---------------- driver / monitor ----------------
  task automatic run_job(input vec_t v, input string name);
    int first_ren, first_wen, done_rel, reads, writes, max_out;
    first_ren = -1; first_wen = -1; done_rel = -1;
    reads = 0; writes = 0; max_out = 0;
    build_model(v.base, v.len, v.rows);
    for (int rel = 0; rel < 2000 && done_rel < 0; rel++) begin
      @(posedge clk); #1;
      Start = (rel == 0) || (rel == v.ign_rel);
      if (rel == 0) begin
        base_addr_in = v.base;
        row_len_in   = RLW'(v.len);
        num_rows_in  = RW'(v.rows);
      end else if (rel == v.ign_rel) begin
        base_addr_in = AW'($urandom);
        row_len_in   = RLW'($urandom_range(1, 31));
        num_rows_in  = RW'($urandom_range(1, 15));
      end
      ready_IFMap = !(rel >= v.st_lo && rel <= v.st_hi) &&
                    (!v.rnd || ($urandom_range(0, 3) != 0));
      @(negedge clk);
      if (rel == 1) chk({name, " busy_after_start"}, busy, 1);
      if (rel >= v.st_lo && rel <= v.st_hi) chk({name, " wen_in_stall"}, wen_buf_IFMap, 0);
      if (mem_ren) begin
        if (first_ren < 0) first_ren = rel;
        reads++;
        if (addr_q.size() == 0) chk({name, " unexpected_read"}, 1, 0);
        else chk({name, " mem_addr"}, mem_addr, addr_q.pop_front());
      end
      if (wen_buf_IFMap) begin
        if (first_wen < 0) first_wen = rel;
        writes++;
        if (exp_q.size() == 0) chk({name, " unexpected_write"}, 1, 0);
        else chk({name, " ifmap_word"}, IFMap, exp_q.pop_front());
      end
      if (reads - writes > max_out) max_out = reads - writes;
      if (done) done_rel = rel;
    end
    @(posedge clk); #1;
    Start       = 1'b0;
    ready_IFMap = 1'b1;
    @(negedge clk);
    chk({name, " done_seen"}, (done_rel >= 0), 1);
    chk({name, " done_one_cycle"}, done, 0);
    chk({name, " idle_after_done"}, busy, 0);
    chk({name, " words_left"}, exp_q.size(), 0);
    chk({name, " reads_left"}, addr_q.size(), 0);
    chk({name, " credit_limit"}, (max_out <= 2), 1);
    if (v.exp_done != -2) chk({name, " done_cycle"}, done_rel, v.exp_done);
    if (v.exp_ren  != -2) chk({name, " first_ren_cycle"}, first_ren, v.exp_ren);
    if (v.exp_wen  != -2) chk({name, " first_wen_cycle"}, first_wen, v.exp_wen);
  endtask

  // ---------------- test ----------------
  vec_t          vecs[7];
  logic [DW-1:0] t10[10];

  initial begin
    t10 = '{20'h0, 20'h0, 20'hFFFFF, 20'h2, 20'hFFFFF, 20'hFFFFE, 20'h2, 20'h0, 20'h1, 20'h1};
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 10; i++) mem[i] = t10[i];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_ren", mem_ren, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset wen", wen_buf_IFMap, 0);
    chk("reset ifmap", IFMap, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Directed vectors
    vecs[0] = mk(8'd0,   10, 1, -9, -9, -9, 1'b1);
    vecs[1] = mk(8'd0,   5,  2, -9, -9, -9, 1'b1);
    vecs[2] = mk(8'd254, 1,  3, -9, -9, -9, 1'b1);
    vecs[3] = mk(8'd0,   10, 1, 4,  9,  -9, 1'b0);
    vecs[4] = mk(8'd0,   0,  3, -9, -9, -9, 1'b1);
    vecs[5] = mk(8'd3,   4,  2, -9, -9, 4,  1'b1);
    vecs[6] = mk(8'd7,   3,  0, -9, -9, -9, 1'b1);
    for (int i = 0; i < 7; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Mid-job reset: the job is aborted, outputs clear, and no writes follow.
    @(posedge clk); #1;
    Start = 1'b1; base_addr_in = 8'd0; row_len_in = 5'd10; num_rows_in = 4'd1;
    @(posedge clk); #1 Start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midreset mem_ren", mem_ren, 0);
    chk("midreset mem_addr", mem_addr, 0);
    chk("midreset wen", wen_buf_IFMap, 0);
    chk("midreset ifmap", IFMap, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postreset no_write", wen_buf_IFMap, 0);
    end
    run_job(vecs[0], "after_reset");

    // Random jobs under random backpressure
    for (int j = 0; j < 8; j++) begin
      vec_t v;
      v     = mk(AW'($urandom), $urandom_range(1, 6), $urandom_range(1, 4), -9, -9, -9, 1'b0);
      v.rnd = 1'b1;
      v.exp_ren = -2;
      v.exp_wen = -2;
      run_job(v, $sformatf("rand%0d", j));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
